// File: rtl/fifo_pkt_pkg.sv
// Shared types and helpers for the FIFO packet reader.
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  localparam int unsigned PREFETCH_DEPTH = 2;

  // Length field lives in the low len_w bits of the header; upper bits are ignored.
  function automatic logic [63:0] len_f(input logic [63:0] hdr, input int unsigned len_w);
    logic [63:0] mask;
    mask = (64'd1 << len_w) - 64'd1;
    return hdr & mask;
  endfunction

endpackage

// File: rtl/fifo_pkt_prefetch.sv
// Two-entry prefetch buffer hiding the FIFO's one-cycle read latency.
module fifo_pkt_prefetch
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_empty,
  input  logic         fifo_valid_out,
  input  logic [W-1:0] fifo_data_out,
  input  logic         pop,
  output logic         fifo_read,
  output logic [W-1:0] head,
  output logic [1:0]   occ,
  output logic         infl
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         push;
  logic [1:0]   committed;

  // Only words we actually requested are captured, so a stray valid right after reset is dropped.
  assign push      = fifo_valid_out && infl;
  assign committed = occ + {1'b0, infl} - {1'b0, pop};
  assign fifo_read = !rst && !fifo_empty && (committed < 2'(PREFETCH_DEPTH));
  assign head      = slot0;

  // Buffer storage, occupancy and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= '0;
      infl  <= 1'b0;
    end else begin
      infl <= fifo_read;
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= fifo_data_out;
          else             slot1 <= fifo_data_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy holds, head advances.
          if (occ == 2'd1) begin
            slot0 <= fifo_data_out;
          end else begin
            slot0 <= slot1;
            slot1 <= fifo_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains length-prefixed packets from a FIFO and emits them as a valid/ready stream.
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned LEN_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  output logic         fifo_read,
  input  logic [W-1:0] fifo_data_out,
  input  logic         fifo_valid_out,
  input  logic         fifo_empty,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         pkt_done,
  output logic         busy
);

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_next;
  logic [LEN_W-1:0] hdr_len;
  logic             pop;
  logic [W-1:0]     head;
  logic [1:0]       occ;
  logic             infl;

  fifo_pkt_prefetch #(
    .W(W)
  ) u_prefetch (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_valid_out(fifo_valid_out),
    .fifo_data_out (fifo_data_out),
    .pop           (pop),
    .fifo_read     (fifo_read),
    .head          (head),
    .occ           (occ),
    .infl          (infl)
  );

  assign hdr_len = LEN_W'(len_f(64'(head), LEN_W));
  assign busy    = (state != IDLE);

  // Next-state, buffer pop and stream outputs.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    pop        = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_data     = '0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (occ != 2'd0 || infl) state_next = HDR;
      end
      HDR: begin
        if (occ != 2'd0) begin
          pop      = 1'b1;
          rem_next = hdr_len;
          if (hdr_len == '0) begin
            pkt_done = 1'b1;
            if (occ == 2'd1 && !infl) state_next = IDLE;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        m_valid = (occ != 2'd0);
        m_data  = m_valid ? head : '0;
        m_last  = m_valid && (rem == LEN_W'(1));
        if (m_valid && m_ready) begin
          pop      = 1'b1;
          rem_next = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            pkt_done   = 1'b1;
            state_next = (occ > 2'd1 || infl) ? HDR : IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and remaining-beat registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
Read-side master for the single-clock FIFO (fifo_sc). It drains length-prefixed packets from the FIFO read port and re-emits them as a valid/ready stream with a last flag. The block hides the FIFO's 1-cycle read latency behind a 2-entry prefetch buffer, so the stream sustains one word per clock. It sits between a packet FIFO and any stream consumer, such as a MAC TX path or a DMA sink.

Parameters:
W, 16, FIFO/stream data width in bits.
LEN_W, 12, width of the length field in the header word, taken from bits [LEN_W-1:0]. Must satisfy LEN_W <= W.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  synchronous, active-high reset.
fifo_read  out  1  read strobe to the FIFO.
fifo_data_out  in  W  FIFO read data; valid when fifo_valid_out=1.
fifo_valid_out  in  1  FIFO read-data valid; asserted the cycle after a read while not empty.
fifo_empty  in  1  FIFO empty flag.
m_valid  out  1  stream word valid.
m_ready  in  1  consumer ready.
m_data  out  W  stream payload word.
m_last  out  1  final payload word of the packet.
pkt_done  out  1  one-cycle pulse when a packet completes (last beat accepted, or zero-length header consumed).
busy  out  1  high while state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - fifo_read=0, m_valid=0, m_last=0, m_data=0, pkt_done=0, busy=0.
  - Prefetch buffer cleared, in-flight count cleared, state=IDLE.
  - fifo_valid_out seen in the cycle right after reset is ignored.
  - Mid-packet reset drops the partial packet with no m_last. rst is driven together with the FIFO's rst.
- Packet format: header word, then L payload words, where L = header[LEN_W-1:0]. Header bits above LEN_W are ignored. The header is never emitted on the stream.
- Prefetch: fifo_read is combinational.
  - fifo_read = !fifo_empty && (occ + infl - pop) < 2
    - occ = buffer occupancy, 0..2.
    - infl = reads issued last cycle, 0..1.
    - pop = buffer head consumed this cycle.
  - A word captured on fifo_valid_out becomes visible at the buffer head the following cycle.
  - Buffer overflow is impossible by construction; the bench checks it with an assertion.
- FSM states: IDLE, HDR, PAYLOAD.
  - IDLE: go to HDR when occ>0 or infl>0. Reads are already permitted in IDLE.
  - HDR: when occ>0, pop the head and load rem=L.
    - L=0: pulse pkt_done, then go to IDLE if occ-1+infl==0, else stay in HDR.
    - L>0: go to PAYLOAD.
  - PAYLOAD: m_valid=(occ>0), m_data=head, m_last=(rem==1). On m_valid&&m_ready: pop, rem--.
    - Last beat accepted: pulse pkt_done; next state HDR if buffer or in-flight data remains, else IDLE.
- Stream rules:
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_valid never deasserts without a handshake. This follows because occ only drops on pop.
- rem is LEN_W bits wide; the maximum packet is 2^LEN_W-1 words.
- Latency: header read at cycle 0 gives first m_valid at cycle 3. With m_ready=1 and the FIFO non-empty, throughput is 1 word/clock, including back-to-back packets. There is a 1-cycle bubble per header.
- fifo_empty mid-packet: m_valid drops only after the buffer drains. No error is raised.
- Simultaneous capture and pop in the same cycle: occ unchanged, head advances.

Decomposition:
- Package fifo_pkt_pkg holds:
  - the state enum typedef (IDLE/HDR/PAYLOAD);
  - the PREFETCH_DEPTH=2 constant;
  - a len_f(hdr) function extracting the length field.
- One sub-module, fifo_pkt_prefetch: a 2-entry register buffer with push, pop, head, occ and credit logic.
- The FSM, rem counter and stream outputs stay in the top level.

Test Plan:
1. Single packet: FIFO holds {0x0003, 0xA1, 0xA2, 0xA3}, m_ready=1. Expect m_data A1,A2,A3 on consecutive cycles; m_last only with A3; first m_valid 3 cycles after the first fifo_read; one pkt_done pulse.
2. Backpressure: same packet, m_ready toggled 1,0,0,1,1. Expect data held stable while stalled; fifo_read never issued with occ+infl>=2; exactly 3 beats delivered.
3. Zero-length then normal: FIFO holds {0x0000, 0x0001, 0xB1}. Expect two pkt_done pulses; stream carries only B1 with m_last=1.
4. Back-to-back packets: {0x0002,C1,C2,0x0002,D1,D2} with m_ready=1. Expect C1,C2,(1 bubble),D1,D2; m_last on C2 and D2.
5. Starvation mid-packet: header says 4, only 2 words present, the rest written 10 cycles later. Expect m_valid low during the gap, no spurious m_last, and completion after the refill.
6. Reset mid-packet: rst asserted after 1 of 3 beats, then a fresh {0x0001,E1}. Expect all outputs at reset values the next cycle; E1 delivered with m_last=1; no stale words.
